// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped, write-back, write-allocate data cache with a line refill/evict FSM
module dcache_controller #(
    parameter int INDEX_BITS = 4,
    parameter int LINE_BITS  = 256
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cpu_req_i,
    input  logic                 cpu_write_i,
    input  logic [31:0]          cpu_addr_i,
    input  logic [31:0]          cpu_data_i,
    output logic [31:0]          cpu_data_o,
    output logic                 cpu_stall_o,
    output logic                 mem_enable_o,
    output logic                 mem_write_o,
    output logic [31:0]          mem_addr_o,
    output logic [LINE_BITS-1:0] mem_data_o,
    input  logic [LINE_BITS-1:0] mem_data_i,
    input  logic                 mem_ack_i
);
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 27 - INDEX_BITS;

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

    state_t                r_state;
    logic                  r_mem_en;
    logic                  r_mem_we;
    logic [31:0]           r_mem_addr;
    logic [LINES-1:0]      r_valid;
    logic [LINES-1:0]      r_dirty;
    logic [TAG_BITS-1:0]   r_tag  [LINES];
    logic [LINE_BITS-1:0]  r_data [LINES];

    logic [TAG_BITS-1:0]   w_tag;
    logic [INDEX_BITS-1:0] w_index;
    logic [2:0]            w_word;
    logic [LINE_BITS-1:0]  w_line;
    logic                  w_idle;
    logic                  w_hit;
    logic                  w_unused;

    assign w_tag    = cpu_addr_i[31:5+INDEX_BITS];
    assign w_index  = cpu_addr_i[4+INDEX_BITS:5];
    assign w_word   = cpu_addr_i[4:2];
    assign w_unused = ^cpu_addr_i[1:0];
    assign w_line   = r_data[w_index];
    assign w_idle   = r_state == IDLE;
    assign w_hit    = cpu_req_i & r_valid[w_index] & (r_tag[w_index] == w_tag);

    // Stall is combinational so the miss-detect cycle is already frozen; forced low while in reset.
    assign cpu_stall_o  = rst_i & cpu_req_i & (~w_idle | ~w_hit);
    assign cpu_data_o   = (w_idle & w_hit & ~cpu_write_i) ? w_line[{w_word, 5'b0} +: 32] : '0;
    assign mem_enable_o = r_mem_en;
    assign mem_write_o  = r_mem_we;
    assign mem_addr_o   = r_mem_addr;
    // The victim line is still indexed by the held CPU address, so it can be decoded from state.
    assign mem_data_o   = (r_state == WRITEBACK) ? w_line : '0;

    // Miss FSM with registered memory request outputs and per-line valid/dirty bookkeeping.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= IDLE;
            r_mem_en   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_valid    <= '0;
            r_dirty    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cpu_req_i & ~w_hit) begin
                        r_mem_en <= 1'b1;
                        if (r_valid[w_index] & r_dirty[w_index]) begin
                            r_state    <= WRITEBACK;
                            r_mem_we   <= 1'b1;
                            r_mem_addr <= {r_tag[w_index], w_index, 5'b0};
                        end else begin
                            r_state    <= ALLOCATE;
                            r_mem_we   <= 1'b0;
                            r_mem_addr <= {w_tag, w_index, 5'b0};
                        end
                    end else if (w_hit & cpu_write_i) begin
                        r_dirty[w_index] <= 1'b1;
                    end
                end
                WRITEBACK: begin
                    if (mem_ack_i) begin
                        r_state    <= ALLOCATE;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= {w_tag, w_index, 5'b0};
                    end
                end
                ALLOCATE: begin
                    if (mem_ack_i) begin
                        r_state          <= IDLE;
                        r_mem_en         <= 1'b0;
                        r_mem_addr       <= '0;
                        r_valid[w_index] <= 1'b1;
                        r_dirty[w_index] <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Tag/data arrays: line fill on refill ack, single-word update on a store hit.
    always_ff @(posedge clk_i) begin
        if (r_state == ALLOCATE && mem_ack_i) begin
            r_data[w_index] <= mem_data_i;
            r_tag[w_index]  <= w_tag;
        end else if (w_idle & w_hit & cpu_write_i) begin
            r_data[w_index][{w_word, 5'b0} +: 32] <= cpu_data_i;
        end
    end
endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller: directed scoreboard bench for the data cache controller
module tb_dcache_controller;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cpu_req = 1'b0;
    logic         cpu_write = 1'b0;
    logic [31:0]  cpu_addr = '0;
    logic [31:0]  cpu_wdata = '0;
    logic [31:0]  cpu_rdata;
    logic         stall;
    logic         mem_en;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [255:0] mem_wdata;
    logic [255:0] mem_rdata = '0;
    logic         r_ack = 1'b0;
    logic         stray_ack = 1'b0;
    logic         mem_ack;

    assign mem_ack = r_ack | stray_ack;

    always #5 clk = ~clk;

    dcache_controller dut (
        .clk_i(clk), .rst_i(rst_n),
        .cpu_req_i(cpu_req), .cpu_write_i(cpu_write), .cpu_addr_i(cpu_addr), .cpu_data_i(cpu_wdata),
        .cpu_data_o(cpu_rdata), .cpu_stall_o(stall),
        .mem_enable_o(mem_en), .mem_write_o(mem_we), .mem_addr_o(mem_addr),
        .mem_data_o(mem_wdata), .mem_data_i(mem_rdata), .mem_ack_i(mem_ack)
    );

    typedef struct {logic wr; logic [31:0] data; int stall;} cpu_exp_t;
    typedef struct {logic we; logic [31:0] addr; logic [255:0] line;} mem_exp_t;

    cpu_exp_t     cpu_q[$];
    mem_exp_t     mem_q[$];
    logic [255:0] model [logic [31:0]];
    int           vectors = 0;
    int           errors = 0;
    int           lat = 1;

    function automatic logic [255:0] gen(input logic [31:0] a);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = 32'h1000_0000 + ((a ^ 32'h40) << 4) + 32'(i);
        return l;
    endfunction

    function automatic logic [255:0] patch(input logic [255:0] l, input int w, input logic [31:0] v);
        l[w*32 +: 32] = v;
        return l;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_cpu_data"}, cpu_rdata, 0);
        chk({tag, "_stall"}, stall, 0);
        chk({tag, "_mem_en"}, mem_en, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_data"}, mem_wdata, 0);
    endtask

    task automatic access(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp, input int st);
        int n;
        cpu_q.push_back('{wr, exp, st});
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_write = wr; cpu_addr = a; cpu_wdata = d;
        n = 0;
        @(negedge clk);
        while (stall && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (stall) begin
            vectors++;
            errors++;
            $display("FAIL timeout: access %0h still stalled after %0d cycles", a, n);
        end
        @(posedge clk); #1;
        cpu_req = 1'b0; cpu_write = 1'b0;
    endtask

    task automatic push_mem(input logic we, input logic [31:0] a, input logic [255:0] l);
        mem_q.push_back('{we, a, l});
    endtask

    // Memory responder: acks on the lat-th cycle of each request, stores write-backs into the model.
    initial begin : resp
        int   cnt;
        logic ack_was;
        cnt = 0;
        forever begin
            @(posedge clk); #1;
            ack_was = r_ack;
            r_ack = 1'b0;
            if (!rst_n || !mem_en) cnt = 0;
            else begin
                cnt = ack_was ? 1 : cnt + 1;
                if (cnt == lat) begin
                    r_ack = 1'b1;
                    if (mem_we) model[mem_addr] = mem_wdata;
                    else mem_rdata = model.exists(mem_addr) ? model[mem_addr] : gen(mem_addr);
                end
            end
        end
    end

    // Monitor: pops expectations whenever the DUT completes an access or issues a memory request.
    initial begin : mon
        int          stall_cnt;
        logic        p_en, p_we, p_ack;
        logic [31:0] p_addr;
        cpu_exp_t    e;
        mem_exp_t    m;
        stall_cnt = 0; p_en = 0; p_we = 0; p_ack = 0; p_addr = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) stall_cnt = 0;
            else if (cpu_req) begin
                if (stall) stall_cnt++;
                else if (cpu_q.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL cpu_unexpected: completion at %0h with nothing expected", cpu_addr);
                end else begin
                    e = cpu_q.pop_front();
                    chk("stall_cycles", stall_cnt, e.stall);
                    if (!e.wr) chk("load_data", cpu_rdata, e.data);
                    stall_cnt = 0;
                end
            end
            if (p_en && p_ack && !p_we) chk("en_after_ack", mem_en, 0);
            if (mem_en && (!p_en || mem_we !== p_we || mem_addr !== p_addr)) begin
                if (mem_q.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL mem_unexpected: request we=%0b addr=%0h", mem_we, mem_addr);
                end else begin
                    m = mem_q.pop_front();
                    chk("mem_we", mem_we, m.we);
                    chk("mem_addr", mem_addr, m.addr);
                    chk("mem_data_o", mem_wdata, m.line);
                end
            end
            p_en = mem_en; p_we = mem_we; p_ack = mem_ack; p_addr = mem_addr;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #3;
        chk_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        lat = 10;
        push_mem(0, 32'h40, '0);
        access(0, 32'h40, 0, 32'h1000_0000, 11);
        access(0, 32'h4C, 0, 32'h1000_0003, 0);
        access(1, 32'h44, 32'hDEAD_BEEF, 0, 0);
        lat = 4;
        push_mem(1, 32'h40, patch(gen(32'h40), 1, 32'hDEAD_BEEF));
        push_mem(0, 32'h240, '0);
        access(0, 32'h240, 0, 32'h1000_2000, 9);
        lat = 3;
        push_mem(0, 32'h80, '0);
        access(1, 32'h80, 32'h1234_5678, 0, 4);
        access(0, 32'h80, 0, 32'h1234_5678, 0);
        access(0, 32'h84, 0, 32'h1000_0C01, 0);
        lat = 2;
        push_mem(1, 32'h80, patch(gen(32'h80), 0, 32'h1234_5678));
        push_mem(0, 32'h280, '0);
        access(0, 32'h280, 0, 32'h1000_2C00, 5);
        lat = 1;
        push_mem(0, 32'h40, '0);
        access(0, 32'h44, 0, 32'hDEAD_BEEF, 2);
        lat = 20;
        push_mem(0, 32'h300, '0);
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 32'h300;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("midreset");
        cpu_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        stray_ack = 1'b1;
        @(posedge clk); #1;
        stray_ack = 1'b0;
        @(negedge clk);
        chk("stray_ack_en", mem_en, 0);
        lat = 2;
        push_mem(0, 32'h40, '0);
        access(0, 32'h40, 0, 32'h1000_0000, 3);
        repeat (3) @(posedge clk);
        chk("cpu_q_left", cpu_q.size(), 0);
        chk("mem_q_left", mem_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate data cache between the CPU MEM stage and a slow, multi-cycle data memory.
- Presents a single-cycle, word-wide hit path to the CPU and stalls the pipeline on misses.
- Refills and evicts whole lines through a request/acknowledge handshake with the memory.

Parameters:
- INDEX_BITS, 4, log2 of line count (16 lines).
- LINE_BITS, 256, line width in bits (32 bytes, 8 words); fixed, sets the 5-bit byte offset.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- cpu_req_i  in  1  MEM stage access valid (load or store).
- cpu_write_i  in  1  1 = store, 0 = load.
- cpu_addr_i  in  32  byte address; word aligned.
- cpu_data_i  in  32  store data.
- cpu_data_o  out  32  load data.
- cpu_stall_o  out  1  freeze pipeline (PC, IF/ID, ID/EX, EX/MEM).
- mem_enable_o  out  1  memory request valid.
- mem_write_o  out  1  1 = line write-back, 0 = line fetch.
- mem_addr_o  out  32  line-aligned address (bits [4:0] = 0).
- mem_data_o  out  256  evicted line.
- mem_data_i  in  256  fetched line.
- mem_ack_i  in  1  one-cycle pulse: request complete, mem_data_i valid on fetch.

Behaviour:
- Address split:
  - tag = addr[31:5+INDEX_BITS]
  - index = addr[4+INDEX_BITS:5]
  - word = addr[4:2]
  - addr[1:0] ignored.
- Per-line storage: valid, dirty, tag, 256-bit data. Word w occupies bits [32w+31:32w].
- hit = cpu_req_i & valid[index] & (tag_store[index] == tag).
- FSM states: IDLE, WRITEBACK, ALLOCATE.
- IDLE:
  - Read hit: cpu_data_o = addressed word, combinational, same cycle. cpu_stall_o = 0.
  - Write hit: on the clock edge, write cpu_data_i into the addressed word and set dirty. cpu_stall_o = 0.
  - Miss with victim valid & dirty: go to WRITEBACK.
  - Miss otherwise: go to ALLOCATE.
- WRITEBACK:
  - Drive mem_enable_o=1, mem_write_o=1, mem_addr_o={victim tag, index, 5'b0}, mem_data_o=victim line.
  - Hold all of these until mem_ack_i, then go to ALLOCATE.
- ALLOCATE:
  - Drive mem_enable_o=1, mem_write_o=0, mem_addr_o={tag, index, 5'b0}.
  - On mem_ack_i: write mem_data_i to the line, set tag, valid=1, dirty=0, go to IDLE.
  - The pending access then hits in IDLE on the next cycle; a store completes there and sets dirty.
- cpu_stall_o = cpu_req_i & (state != IDLE | ~hit). Combinational, so the stall covers the miss-detect cycle.
- CPU contract: while cpu_stall_o=1, cpu_req_i, cpu_write_i, cpu_addr_i and cpu_data_i are held stable. The controller does not latch them.
- Memory outputs:
  - mem_enable_o deasserts the cycle after ack. No back-to-back request is issued without a state change.
  - mem_* outputs are registered or state-decoded. They must not depend combinationally on mem_ack_i.
  - mem_data_o = 0 and mem_write_o = 0 outside WRITEBACK. mem_addr_o = 0 in IDLE.
- cpu_data_o = 0 when not (state==IDLE & hit & ~cpu_write_i).
- Stall length:
  - Clean miss: L+1 cycles, where L is the number of cycles from request to ack inclusive.
  - Dirty miss: Lwb + Lfetch + 1 cycles.
- mem_ack_i in IDLE is ignored.
- cpu_req_i dropping mid-miss is illegal by contract. If it occurs, the FSM still completes the current WRITEBACK/ALLOCATE sequence.
- Reset (rst_i=0), async, also mid-transaction:
  - state=IDLE; all valid and dirty bits = 0.
  - All outputs 0 immediately.
  - Tag and data arrays need not be reset.
  - An in-flight memory request is abandoned. A late mem_ack_i after reset release is ignored in IDLE.

Test Plan:
- Cold read miss: reset, load 0x0000_0040 with memory returning a line whose word i = 0x1000_0000+i, ack after 10 cycles → mem_enable_o=1, mem_write_o=0, mem_addr_o=0x40 for 10 cycles; stall 11 cycles; then cpu_data_o=0x1000_0000 with stall=0.
- Hit path: after the previous case, load 0x4C → same cycle cpu_data_o=0x1000_0003, cpu_stall_o=0, mem_enable_o=0.
- Write hit then dirty eviction:
  - Store 0xDEADBEEF to 0x44 → no stall.
  - Then load 0x0000_0240 (same index 2, different tag) → WRITEBACK with mem_addr_o=0x40 and mem_data_o bits [63:32]=0xDEADBEEF, then ALLOCATE with mem_addr_o=0x240, then hit.
- Write miss allocate: store 0x12345678 to clean-miss 0x80 → fetch 0x80; after ack, word 0 = 0x12345678 and dirty=1; a later conflicting miss on 0x280 writes back line 0x80.
- Reset mid-ALLOCATE: drop rst_i 3 cycles into a fetch → all outputs 0 asynchronously; stray mem_ack_i after release ignored; re-reading 0x40 misses again (valid cleared).
- Held ack timing: ack arrives on the first request cycle (L=1) → stall exactly 2 cycles; mem_enable_o low the cycle after ack.
